// File: rtl/de2_70_onchip_mem_copier.sv
// de2_70_onchip_mem_copier
//   Avalon-MM master that copies a block of 32-bit words from a source byte
//   address range to a destination byte address range, one word at a time.
//   For each word it reads once, waits for the data, and then writes it.
//
// Ports
//   clk, reset          single clock; synchronous active-high reset
//   start               1-cycle command strobe, only honoured in idle
//   src_addr, dst_addr  byte addresses; the two low bits are forced to zero
//   num_words           number of words to copy (0 completes immediately)
//   busy                high while a copy is in progress
//   done                1-cycle completion pulse
//   m_*                 Avalon-MM master port (one transfer outstanding at most)

module de2_70_onchip_mem_copier #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned LEN_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic [31:0]       m_writedata,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid
);

  typedef enum logic [2:0] {StIdle, StRd, StRwait, StWr, StFin} state_e;

  localparam logic [ADDR_W-1:0] WordStep  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       wdata_q, wdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    busy      = 1'b0;
    done      = 1'b0;
    m_read    = 1'b0;
    m_write   = 1'b0;
    m_address = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = src_addr & AlignMask;
          dst_d   = dst_addr & AlignMask;
          cnt_d   = num_words;
          state_d = (num_words == '0) ? StFin : StRd;
        end
      end
      StRd: begin
        busy      = 1'b1;
        m_read    = 1'b1;
        m_address = src_q;
        if (!m_waitrequest) state_d = StRwait;
      end
      StRwait: begin
        // Any readdatavalid seen in StRd is ignored; only this state captures.
        busy = 1'b1;
        if (m_readdatavalid) begin
          wdata_d = m_readdata;
          state_d = StWr;
        end
      end
      StWr: begin
        busy      = 1'b1;
        m_write   = 1'b1;
        m_address = dst_q;
        if (!m_waitrequest) begin
          // Pointers wrap naturally at ADDR_W bits.
          src_d   = src_q + WordStep;
          dst_d   = dst_q + WordStep;
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == LEN_W'(1)) ? StFin : StRd;
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign m_byteenable = 4'hF;
  assign m_writedata  = wdata_q;

endmodule

// File: tb/tb_de2_70_onchip_mem_copier.sv
// Testbench for de2_70_onchip_mem_copier: behavioural memory slave with
// random stalls, reference copy model feeding expected-transfer queues, and a
// monitor that pops and compares on every accepted read/write.

module tb_de2_70_onchip_mem_copier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] src_addr, dst_addr;
  logic [12:0] num_words;
  logic        busy, done;
  logic [13:0] m_address;
  logic        m_read, m_write;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;

  de2_70_onchip_mem_copier #(.ADDR_W(14), .LEN_W(13)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .num_words      (num_words),
    .busy           (busy),
    .done           (done),
    .m_address      (m_address),
    .m_read         (m_read),
    .m_write        (m_write),
    .m_byteenable   (m_byteenable),
    .m_writedata    (m_writedata),
    .m_waitrequest  (m_waitrequest),
    .m_readdata     (m_readdata),
    .m_readdatavalid(m_readdatavalid)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  logic [31:0] mem     [4096];   // slave memory
  logic [31:0] ref_mem [4096];   // reference model memory

  logic [13:0] exp_rd_q[$];
  logic [13:0] exp_wa_q[$];
  logic [31:0] exp_wd_q[$];

  int unsigned done_cnt = 0, exp_done = 0, last_done_cyc = 0, start_cyc = 0;
  int unsigned wr_acc = 0, rd_acc = 0;
  bit          stall_en = 1'b0;

  // slave/monitor state
  bit          rd_pend = 1'b0;
  logic [11:0] rd_idx;
  bit          stalled_prev = 1'b0;
  logic [13:0] p_addr;
  logic        p_read, p_write;
  logic [31:0] p_wdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory slave plus scoreboard monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      rd_pend         = 1'b0;
      stalled_prev    = 1'b0;
      m_readdatavalid = 1'b0;
      m_waitrequest   = 1'b0;
    end else begin
      if (stalled_prev) begin
        chk("stall_addr", {18'd0, m_address}, {18'd0, p_addr});
        chk("stall_rw", {30'd0, m_read, m_write}, {30'd0, p_read, p_write});
        chk("stall_wdata", m_writedata, p_wdata);
      end
      if (m_read && m_write) chk("rd_wr_excl", 32'd1, 32'd0);
      m_waitrequest   = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
      m_readdatavalid = rd_pend;
      m_readdata      = rd_pend ? mem[rd_idx] : $urandom;
      rd_pend         = 1'b0;
      if (m_read && !m_waitrequest) begin
        rd_acc++;
        if (exp_rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else chk("rd_addr", {18'd0, m_address}, {18'd0, exp_rd_q.pop_front()});
        rd_pend = 1'b1;
        rd_idx  = m_address[13:2];
        // Spurious valid in the accept cycle must be ignored by the master.
        if ($urandom_range(0, 1) == 1) begin
          m_readdatavalid = 1'b1;
          m_readdata      = 32'hDEAD_BEEF;
        end
      end
      if (m_write && !m_waitrequest) begin
        wr_acc++;
        chk("byteenable", {28'd0, m_byteenable}, 32'hF);
        if (exp_wa_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else begin
          chk("wr_addr", {18'd0, m_address}, {18'd0, exp_wa_q.pop_front()});
          chk("wr_data", m_writedata, exp_wd_q.pop_front());
        end
        mem[m_address[13:2]] = m_writedata;
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
      stalled_prev = (m_read || m_write) && m_waitrequest;
      p_addr  = m_address;
      p_read  = m_read;
      p_write = m_write;
      p_wdata = m_writedata;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference model: sequential word copy with modular addressing.
  task automatic start_copy(input logic [13:0] s, input logic [13:0] d, input logic [12:0] n);
    logic [13:0] sb, db, ra, wa;
    sb = s & 14'h3FFC;
    db = d & 14'h3FFC;
    for (int i = 0; i < int'(n); i++) begin
      ra = sb + 14'(4 * i);
      wa = db + 14'(4 * i);
      exp_rd_q.push_back(ra);
      ref_mem[wa[13:2]] = ref_mem[ra[13:2]];
      exp_wa_q.push_back(wa);
      exp_wd_q.push_back(ref_mem[wa[13:2]]);
    end
    exp_done++;
    wr_acc    = 0;
    start     = 1'b1;
    src_addr  = s;
    dst_addr  = d;
    num_words = n;
    start_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int unsigned budget);
    int unsigned k;
    k = 0;
    while (done_cnt < exp_done && k < budget) begin
      step();
      k++;
    end
    chk({name, "_done_cnt"}, done_cnt, exp_done);
    chk({name, "_rd_q_empty"}, exp_rd_q.size(), 0);
    chk({name, "_wr_q_empty"}, exp_wa_q.size(), 0);
  endtask

  initial begin
    int unsigned k, rd_before;
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; num_words = '0;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[i]     = 32'hA000_0000 + i;
      ref_mem[i] = mem[i];
    end
    repeat (3) step();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_rw", {30'd0, m_read, m_write}, 0);
    chk("rst_addr", {18'd0, m_address}, 0);
    chk("rst_wdata", m_writedata, 0);
    reset = 1'b0;
    step();

    // 1: four words, no stalls, timing
    start_copy(14'h000, 14'h100, 13'd4);
    wait_done("t1", 100);
    chk("t1_latency", last_done_cyc - start_cyc, 13);
    repeat (2) step();

    // 2: zero-length copy
    rd_before = rd_acc;
    start_copy(14'h000, 14'h200, 13'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_busy", {31'd0, busy}, 0);
      chk("t2_rw", {30'd0, m_read, m_write}, 0);
      step();
    end
    wait_done("t2", 10);
    chk("t2_latency", last_done_cyc - start_cyc, 1);
    chk("t2_no_reads", rd_acc - rd_before, 0);
    repeat (2) step();

    // 3: sixteen words with random stalls
    stall_en = 1'b1;
    start_copy(14'h400, 14'h800, 13'd16);
    wait_done("t3", 3000);
    stall_en = 1'b0;
    for (int i = 0; i < 16; i += 5)
      chk("t3_dst_mem", mem[12'h200 + 12'(i)], mem[12'h100 + 12'(i)]);
    repeat (2) step();

    // 4: source wraps past the top of the address space
    start_copy(14'h3FFC, 14'h0000, 13'd2);
    wait_done("t4", 100);
    chk("t4_word1", mem[1], mem[4095]);
    repeat (2) step();

    // 5: reset during WR of word 2 of 8
    start_copy(14'h1000, 14'h1800, 13'd8);
    k = 0;
    while (!(wr_acc == 1 && m_write) && k < 200) begin
      step();
      k++;
    end
    chk("t5_reached_wr2", {31'd0, (wr_acc == 1 && m_write)}, 1);
    reset = 1'b1;
    step();
    chk("t5_rw_after_rst", {30'd0, m_read, m_write}, 0);
    chk("t5_busy_after_rst", {31'd0, busy}, 0);
    chk("t5_wdata_after_rst", m_writedata, 0);
    reset = 1'b0;
    exp_rd_q.delete();
    exp_wa_q.delete();
    exp_wd_q.delete();
    exp_done--;
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
    step();
    chk("t5_abort_no_done", done_cnt, exp_done);
    start_copy(14'h0010, 14'h0020, 13'd1);
    wait_done("t5", 50);
    repeat (2) step();

    // 6: start during RWAIT is ignored; misaligned source
    start_copy(14'h0003, 14'h0300, 13'd3);
    k = 0;
    while (!(busy && !m_read && !m_write) && k < 50) begin
      step();
      k++;
    end
    chk("t6_reached_rwait", {31'd0, busy && !m_read && !m_write}, 1);
    start = 1'b1; src_addr = 14'h0040; dst_addr = 14'h0500; num_words = 13'd5;
    step();
    start = 1'b0;
    wait_done("t6", 100);
    repeat (20) step();
    chk("t6_single_done", done_cnt, exp_done);
    chk("t6_idle", {31'd0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
